cpu_fetch_queue: RTL and testbench
==================================

CPU_FETCH_QUEUE -- requirements
Module: CPU_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, >= 2).
REQ-002 SHALL have parameter ADDR_WIDTH, default `VIRTUAL_ADDR_WIDTH, instruction address width.
REQ-003 SHALL have parameter INSTR_WIDTH, default 32, instruction word width.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 SHALL have port in_valid  input  1  fetch stage has a word (fetch cache hit, no jump).
REQ-007 SHALL have port in_pc  input  ADDR_WIDTH  PC of the fetched word.
REQ-008 SHALL have port in_instr  input  INSTR_WIDTH  fetched instruction.
REQ-009 SHALL have port in_tlb_fault  input  1  fetch used TLB and missed; the word is invalid and decode must trap.
REQ-010 SHALL have port in_ready  output  1  queue accepts a word this cycle; fetch holds PC when low.
REQ-011 SHALL have port out_valid  output  1  head entry is available to decode.
REQ-012 SHALL have port out_pc  output  ADDR_WIDTH  head entry PC.
REQ-013 SHALL have port out_instr  output  INSTR_WIDTH  head entry instruction.
REQ-014 SHALL have port out_tlb_fault  output  1  head entry fault flag.
REQ-015 SHALL have port out_ready  input  1  decode consumes the head this cycle.
REQ-016 SHALL have port flush  input  1  jump or exception redirect from a later stage.
REQ-017 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-018 Push occurs iff in_valid && in_ready && !flush; entry {in_pc, in_instr, in_tlb_fault} written at the tail, tail pointer +1 mod DEPTH.
REQ-019 Pop occurs iff out_valid && out_ready && !flush; head pointer +1 mod DEPTH.
REQ-020 in_ready SHALL equal (count < DEPTH), from registered state only (no combinational path from out_ready).
REQ-021 out_valid SHALL equal (count != 0); out_pc/out_instr/out_tlb_fault SHALL be the head entry, registered storage, no bypass.
REQ-022 Latency: a word pushed into an empty queue appears on out_valid the next cycle (1 cycle minimum).
REQ-023 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-024 Full (count == DEPTH): in_ready low; a push attempt is dropped even if a pop occurs that cycle.
REQ-025 Empty: out_valid low; out_ready ignored, pointers unchanged.
REQ-026 Pointers SHALL be $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0; count tracks occupancy separately.
REQ-027 flush SHALL, at the next edge, set head = tail = 0 and count = 0; any push or pop in the same cycle is discarded.
REQ-028 Entry storage contents need not be cleared on flush or reset; only valid state (count, pointers) matters.
REQ-029 Entry order SHALL be strictly FIFO; fault entries are passed in order like normal entries.
REQ-030 Out-of-range input values (X on in_pc/in_instr when in_valid low) SHALL NOT affect state.

Reset
REQ-031 When reset = 0, asynchronously: head = 0, tail = 0, count = 0; hence out_valid = 0, in_ready = 1.
REQ-032 Reset asserted mid-operation SHALL discard all entries; first push after release is accepted on the first rising edge with reset = 1.
REQ-033 Outputs out_pc/out_instr/out_tlb_fault are don't-care while out_valid = 0.

Structure
REQ-034 The entry record type (pc, instr, tlb_fault) SHALL be a packed struct in CPU_types.vh; DEPTH default SHALL be a `FETCH_QUEUE_DEPTH define in CPU_define.vh.
REQ-035 Single module, no sub-modules; storage is a register array indexed by head/tail.

Verification
REQ-036 Reset, then push pc=0x1000 instr=0x00000013 -> next cycle out_valid=1, out_pc=0x1000, count=1.
REQ-037 Push 4 words pc=0x1000..0x100C with out_ready=0 -> count=4, in_ready=0; 5th push (0x1010) dropped; drain yields 0x1000,0x1004,0x1008,0x100C in order.
REQ-038 Push and pop every cycle for 10 cycles from count=2 -> count stays 2, pointers wrap, output order matches input order.
REQ-039 count=3 plus flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1; pushed word absent.
REQ-040 Push with in_tlb_fault=1 at pc=0x2000 between two normal words -> out_tlb_fault=1 only when out_pc=0x2000.
REQ-041 Assert reset=0 asynchronously (between edges) at count=2 -> out_valid falls immediately, count=0; push after release accepted.

Source files
------------

// File: rtl/cpu_fetch_queue_pkg.sv
// Shared configuration and entry record for the fetch-to-decode queue.
`default_nettype none

package cpu_fetch_queue_pkg;

  localparam int VIRTUAL_ADDR_WIDTH = 32;
  localparam int FETCH_QUEUE_DEPTH  = 4;
  localparam int FETCH_INSTR_WIDTH  = 32;

  // Entry record at the default widths; the queue itself stores a flat vector
  // in this same field order so that it also works with overridden widths.
  typedef struct packed {
    logic [VIRTUAL_ADDR_WIDTH-1:0] pc;
    logic [FETCH_INSTR_WIDTH-1:0]  instr;
    logic                          tlb_fault;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/cpu_fetch_queue.sv
// Fetch-to-decode instruction queue: registered FIFO with flush and per-entry TLB fault flag.
`default_nettype none

module cpu_fetch_queue
  import cpu_fetch_queue_pkg::*;
#(
  parameter int DEPTH       = FETCH_QUEUE_DEPTH,
  parameter int ADDR_WIDTH  = VIRTUAL_ADDR_WIDTH,
  parameter int INSTR_WIDTH = FETCH_INSTR_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [ADDR_WIDTH-1:0]      in_pc,
  input  logic [INSTR_WIDTH-1:0]     in_instr,
  input  logic                       in_tlb_fault,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [ADDR_WIDTH-1:0]      out_pc,
  output logic [INSTR_WIDTH-1:0]     out_instr,
  output logic                       out_tlb_fault,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + INSTR_WIDTH + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic               push;
  logic               pop;

  // Handshakes depend on registered occupancy only, so out_ready never reaches in_ready.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign {out_pc, out_instr, out_tlb_fault} = mem[head];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; only the pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem[tail] <= {in_pc, in_instr, in_tlb_fault};
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_fetch_queue.sv
// Directed self-checking bench for cpu_fetch_queue at default parameters.
`default_nettype none

module tb_cpu_fetch_queue;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_tlb_fault;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_tlb_fault;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;

  int checks;
  int failures;

  cpu_fetch_queue #(
    .DEPTH       (4),
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_pc         (in_pc),
    .in_instr      (in_instr),
    .in_tlb_fault  (in_tlb_fault),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_tlb_fault (out_tlb_fault),
    .out_ready     (out_ready),
    .flush         (flush),
    .count         (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic fault, input logic ordy, input logic fl);
    in_valid     = v;
    in_pc        = pc;
    in_instr     = instr;
    in_tlb_fault = fault;
    out_ready    = ordy;
    flush        = fl;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    idle();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_count",     32'(count),     32'd0);
    step();
    step();
    reset = 1'b1;

    // Single push into empty queue, then pop
    drive(1'b1, 32'h1000, 32'h00000013, 1'b0, 1'b0, 1'b0);
    step();
    check("p1_out_valid", 32'(out_valid), 32'd1);
    check("p1_out_pc",    out_pc,         32'h1000);
    check("p1_out_instr", out_instr,      32'h00000013);
    check("p1_count",     32'(count),     32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    step();
    check("p1_drained", 32'(count), 32'd0);
    // Empty: out_ready must not move anything
    step();
    check("empty_pop_count", 32'(count), 32'd0);
    check("empty_out_valid", 32'(out_valid), 32'd0);

    // Fill to DEPTH, drop pushes while full
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1000 + 32'(4 * i), 32'hA000 + 32'(i), 1'b0, 1'b0, 1'b0);
      step();
    end
    check("full_count",    32'(count),    32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h1010, 32'hBAD0, 1'b0, 1'b0, 1'b0);
    step();
    check("full_drop_count", 32'(count), 32'd4);
    drive(1'b1, 32'h1014, 32'hBAD1, 1'b0, 1'b1, 1'b0);
    #1;
    check("full_head0", out_pc, 32'h1000);
    step();
    check("full_pop_push_count", 32'(count), 32'd3);
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      #1;
      check("drain_pc",    out_pc,    32'h1000 + 32'(4 * i));
      check("drain_instr", out_instr, 32'hA000 + 32'(i));
      step();
    end
    check("drain_empty", 32'(out_valid), 32'd0);

    // Streaming at count=2 across pointer wrap
    drive(1'b1, 32'h3000, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h3004, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h3008 + 32'(4 * i), 32'h0, 1'b0, 1'b1, 1'b0);
      #1;
      check("stream_pc", out_pc, 32'h3000 + 32'(4 * i));
      step();
      check("stream_count", 32'(count), 32'd2);
    end
    idle();
    out_ready = 1'b1;
    #1;
    check("stream_tail0", out_pc, 32'h3028);
    step();
    check("stream_tail1", out_pc, 32'h302C);
    step();
    check("stream_empty", 32'(count), 32'd0);

    // Fault entry between two normal entries
    drive(1'b1, 32'h1F00, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h2000, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h2004, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    #1;
    check("flt0_pc", out_pc, 32'h1F00);
    check("flt0_f",  32'(out_tlb_fault), 32'd0);
    step();
    check("flt1_pc", out_pc, 32'h2000);
    check("flt1_f",  32'(out_tlb_fault), 32'd1);
    step();
    check("flt2_pc", out_pc, 32'h2004);
    check("flt2_f",  32'(out_tlb_fault), 32'd0);
    step();
    check("flt_empty", 32'(count), 32'd0);

    // Flush at count=3 with concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h6000 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 1'b0);
      step();
    end
    check("pre_flush_count", 32'(count), 32'd3);
    drive(1'b1, 32'hDEAD, 32'h0, 1'b0, 1'b1, 1'b1);
    step();
    check("flush_count",     32'(count),     32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready",  32'(in_ready),  32'd1);
    drive(1'b1, 32'h4000, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("post_flush_count", 32'(count), 32'd1);
    check("post_flush_pc",    out_pc,     32'h4000);
    idle();
    out_ready = 1'b1;
    step();

    // Asynchronous reset between edges at count=2
    drive(1'b1, 32'h7000, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h7004, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("pre_rst_count", 32'(count), 32'd2);
    idle();
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_count",     32'(count),     32'd0);
    check("async_in_ready",  32'(in_ready),  32'd1);
    step();
    drive(1'b1, 32'h5000, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    step();
    check("post_rst_count", 32'(count), 32'd1);
    check("post_rst_pc",    out_pc,     32'h5000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
